// File: rtl/fm_tx_pkg.sv
// Shared FM transmitter definitions: receiver state encoding, default audio
// width and the word-select channel values.
package fm_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } rx_state_t;

    localparam int   AUDIO_W  = 8;
    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// Two-stage synchroniser for one asynchronous input bit.
module sync_ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Capture the raw input, then let a second flop absorb metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/i2s_receiver.sv
// Oversampled I2S / left-justified receiver. Extracts one channel per frame
// and emits the top A bits of that slot as a signed sample with a 1-clk strobe.
module i2s_receiver
    import fm_tx_pkg::*;
#(
    parameter int A       = AUDIO_W,
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         i2s_bclk,
    input  logic         i2s_ws,
    input  logic         i2s_sd,
    input  logic         audio_chan_sel,
    input  logic         i2s_ws_align,
    output logic [A-1:0] sample,
    output logic         sample_valid,
    output logic         locked
);

    localparam int                CNT_W    = $clog2(W);
    localparam int                TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(A - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(W - 1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);

    logic            w_bclk_s;
    logic            w_ws_s;
    logic            w_sd_s;

    logic            r_bclk_d;
    logic            r_rise;
    logic            r_ws_d;
    logic            r_sd_d;
    logic            r_ws_prev;
    rx_state_t       r_state;
    rx_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [A-1:0]    r_shift;
    logic [TO_W-1:0] r_to_cnt;

    logic            w_ws_edge;
    logic            w_new_sel;
    logic            w_timeout;
    logic            w_start;
    logic            w_shift_en;
    logic            w_cap;
    logic [A-1:0]    w_cap_data;
    logic [A-1:0]    w_shift_bit;
    logic [A-1:0]    w_start_shift;

    sync_ff u_sync_bclk (.clk(clk), .rst(rst), .i_d(i2s_bclk), .o_q(w_bclk_s));
    sync_ff u_sync_ws   (.clk(clk), .rst(rst), .i_d(i2s_ws),   .o_q(w_ws_s));
    sync_ff u_sync_sd   (.clk(clk), .rst(rst), .i_d(i2s_sd),   .o_q(w_sd_s));

    // Edge stage: register the BCLK rise strobe and keep WS/SD aligned with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bclk_d <= 1'b0;
            r_rise   <= 1'b0;
            r_ws_d   <= 1'b0;
            r_sd_d   <= 1'b0;
        end else begin
            r_bclk_d <= w_bclk_s;
            r_rise   <= w_bclk_s & ~r_bclk_d;
            r_ws_d   <= w_ws_s;
            r_sd_d   <= w_sd_s;
        end
    end

    // WS seen at the previous rise; tracked even while idle so resync is clean
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ws_prev <= 1'b0;
        end else if (r_rise) begin
            r_ws_prev <= r_ws_d;
        end
    end

    assign w_ws_edge     = (r_ws_d != r_ws_prev);
    assign w_new_sel     = ((r_ws_d == WS_LEFT)  && !audio_chan_sel) ||
                           ((r_ws_d == WS_RIGHT) &&  audio_chan_sel);
    assign w_timeout     = (r_to_cnt == TO_MAX) && !r_rise;
    // Left-justified slots carry their MSB on the very rise that shows the WS edge
    assign w_start_shift = {i2s_ws_align & r_sd_d, {(A-1){1'b0}}};

    // Next-state and capture decisions; a WS edge always closes the open slot
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_cap       = 1'b0;
        w_cap_data  = r_shift;
        w_shift_bit = r_shift;
        for (int i = 0; i < A; i++) begin
            if (r_bit_cnt == CNT_W'(A - 1 - i)) begin
                w_shift_bit[i] = r_sd_d;
            end
        end
        if (!ena || w_timeout) begin
            w_state_nxt = ST_IDLE;
        end else if (r_rise) begin
            if (w_ws_edge) begin
                w_start     = 1'b1;
                w_state_nxt = w_new_sel ? ST_SHIFT : ST_DONE;
                // Short slot: emit whatever arrived, already left-justified
                if (r_state == ST_SHIFT) begin
                    w_cap      = 1'b1;
                    w_cap_data = r_shift;
                end
            end else if (r_state == ST_SHIFT) begin
                w_shift_en = 1'b1;
                if (r_bit_cnt == LAST_BIT) begin
                    w_cap       = 1'b1;
                    w_cap_data  = w_shift_bit;
                    w_state_nxt = ST_DONE;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot bit counter; I2S mode discards the edge bit so counting starts at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
        end else if (w_start) begin
            r_bit_cnt <= i2s_ws_align ? CNT_W'(1) : '0;
        end else if (r_rise && (r_bit_cnt != CNT_SAT)) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    // Shift register, MSB-first into fixed positions; cleared at every slot start
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_shift <= w_start_shift;
        end else if (w_shift_en) begin
            r_shift <= w_shift_bit;
        end
    end

    // Clock cycles since the last BCLK rise, saturating at TIMEOUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_rise) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Output stage: sample held between captures, lock follows capture/loss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= w_cap;
            if (w_cap) begin
                sample <= w_cap_data;
            end
            if (!ena || w_timeout) begin
                locked <= 1'b0;
            end else if (w_cap) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: a slot-level reference model turns the
// driven serial stream into expected samples; a monitor checks each strobe.
module tb_i2s_receiver;

    localparam int A  = 8;
    localparam int TO = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         i2s_bclk;
    logic         i2s_ws;
    logic         i2s_sd;
    logic         audio_chan_sel;
    logic         i2s_ws_align;
    logic [A-1:0] sample;
    logic         sample_valid;
    logic         locked;

    longint cyc = 0;
    int     n_checks = 0;
    int     n_err = 0;

    typedef struct {
        logic [A-1:0] data;
        longint       cyc;
    } exp_t;
    exp_t exp_q[$];

    // reference model state (slot view of the wire)
    logic m_prev_ws;
    logic m_active;
    logic m_sel;
    logic m_emitted;
    logic m_locked;
    logic m_slot[$];
    logic tx_prev_sd;

    i2s_receiver #(.A(A), .W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .i2s_bclk(i2s_bclk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
        .audio_chan_sel(audio_chan_sel), .i2s_ws_align(i2s_ws_align),
        .sample(sample), .sample_valid(sample_valid), .locked(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_emit(input longint rc);
        exp_t e;
        e.data = '0;
        foreach (m_slot[i]) e.data[A-1-i] = m_slot[i];
        e.cyc = rc + 4;
        exp_q.push_back(e);
        m_emitted = 1'b1;
        m_locked  = 1'b1;
    endfunction

    function automatic void model_take(input logic sd, input longint rc);
        m_slot.push_back(sd);
        if (m_slot.size() == A) model_emit(rc);
    endfunction

    // One BCLK rise as seen on the wire, with the mode pins at that moment
    function automatic void model_bit(input logic ws, input logic sd, input longint rc);
        if (!ena) begin
            m_active  = 1'b0;
            m_prev_ws = ws;
            return;
        end
        if (ws != m_prev_ws) begin
            if (m_active && m_sel && !m_emitted) model_emit(rc);
            m_active  = 1'b1;
            m_sel     = (ws == audio_chan_sel);
            m_emitted = 1'b0;
            m_slot.delete();
            m_prev_ws = ws;
            if (i2s_ws_align) model_take(sd, rc);
        end else if (m_active && m_sel && !m_emitted) begin
            model_take(sd, rc);
        end
    endfunction

    function automatic void model_idle();
        m_active = 1'b0;
        m_locked = 1'b0;
        m_slot.delete();
    endfunction

    function automatic void model_reset();
        model_idle();
        m_prev_ws = 1'b0;
    endfunction

    task automatic send_bit(input logic ws, input logic sd);
        @(negedge clk);
        i2s_bclk = 1'b0;
        i2s_ws   = ws;
        i2s_sd   = sd;
        repeat (3) @(negedge clk);
        i2s_bclk = 1'b1;
        model_bit(ws, sd, cyc);
        repeat (4) @(negedge clk);
    endtask

    // Bits k0..k1-1 of a len-bit word; I2S framing delays SD by one BCLK
    task automatic send_bits(input logic ws, input logic [63:0] d, input int len, input logic lj,
                             input int k0, input int k1, input int toggle_at);
        for (int k = k0; k < k1; k++) begin
            logic b;
            b = d[len-1-k];
            if (k == toggle_at) audio_chan_sel = ~audio_chan_sel;
            if (lj) send_bit(ws, b);
            else    send_bit(ws, tx_prev_sd);
            tx_prev_sd = b;
        end
    endtask

    task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int len,
                              input logic lj, input int toggle_r);
        send_bits(1'b0, l, len, lj, 0, len, -1);
        send_bits(1'b1, r, len, lj, 0, len, toggle_r);
    endtask

    task automatic drain(input string nm);
        repeat (8) @(negedge clk);
        check({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every strobe must match the oldest expected capture and its cycle
    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_valid: sample=%0h, expected no strobe (t=%0t)", sample, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sample", 64'(sample), 64'(e.data));
                check("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        int lens[6];
        lens = '{8, 12, 16, 24, 32, 40};
        rst = 1'b1; ena = 1'b1; i2s_bclk = 1'b0; i2s_ws = 1'b0; i2s_sd = 1'b0;
        audio_chan_sel = 1'b0; i2s_ws_align = 1'b0; tx_prev_sd = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_sample", 64'(sample), 64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        rst = 1'b0;

        // standard I2S, left channel
        repeat (4) send_frame(64'hA5000000, 64'h3C000000, 32, 1'b0, -1);
        drain("t1");
        check("t1_locked", 64'(locked), 64'(m_locked));

        // right channel, then a mid-slot channel toggle
        audio_chan_sel = 1'b1;
        repeat (3) send_frame(64'hA5000000, 64'h3C000000, 32, 1'b0, -1);
        send_frame(64'hA5000000, 64'h3C000000, 32, 1'b0, 3);
        repeat (2) send_frame(64'hA5000000, 64'h3C000000, 32, 1'b0, -1);
        drain("t2");

        // left-justified stream, matched and mismatched alignment
        i2s_ws_align = 1'b1;
        repeat (3) send_frame(64'hA5000000, 64'h3C000000, 32, 1'b1, -1);
        i2s_ws_align = 1'b0;
        repeat (3) send_frame(64'hA5000000, 64'h3C000000, 32, 1'b1, -1);
        drain("t3");

        // 6-bit short slots closed by the WS edge
        i2s_ws_align = 1'b1;
        repeat (4) send_frame(64'h2D, 64'($urandom_range(0, 63)), 6, 1'b1, -1);
        drain("t4");

        // BCLK stall mid-slot drops lock; restart must wait for a WS edge
        i2s_ws_align = 1'b0;
        repeat (2) send_frame(64'hA5000000, 64'h3C000000, 32, 1'b0, -1);
        send_bits(1'b0, 64'h5A000000, 32, 1'b0, 0, 4, -1);
        repeat (TO - 30) @(negedge clk);
        check("t5_locked_before_timeout", 64'(locked), 64'd1);
        repeat (50) @(negedge clk);
        check("t5_locked_after_timeout", 64'(locked), 64'd0);
        model_idle();
        send_bits(1'b0, 64'h5A000000, 32, 1'b0, 4, 32, -1);
        send_bits(1'b1, 64'h3C000000, 32, 1'b0, 0, 32, -1);
        repeat (2) send_frame(64'h81000000, 64'h3C000000, 32, 1'b0, -1);
        drain("t5");
        check("t5_relocked", 64'(locked), 64'(m_locked));

        // reset mid-slot
        send_bits(1'b0, 64'hC3000000, 32, 1'b0, 0, 5, -1);
        i2s_bclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_sample", 64'(sample), 64'd0);
        check("t6_rst_valid", 64'(sample_valid), 64'd0);
        check("t6_rst_locked", 64'(locked), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        send_bits(1'b0, 64'hC3000000, 32, 1'b0, 5, 32, -1);
        send_bits(1'b1, 64'h3C000000, 32, 1'b0, 0, 32, -1);
        repeat (2) send_frame(64'h7E000000, 64'h11000000, 32, 1'b0, -1);
        drain("t6_rst");

        // enable dropped mid-slot
        send_bits(1'b0, 64'h99000000, 32, 1'b0, 0, 5, -1);
        ena = 1'b0;
        model_idle();
        @(posedge clk);
        #1;
        check("t6_ena_valid", 64'(sample_valid), 64'd0);
        check("t6_ena_locked", 64'(locked), 64'd0);
        send_bits(1'b0, 64'h99000000, 32, 1'b0, 5, 12, -1);
        ena = 1'b1;
        send_bits(1'b0, 64'h99000000, 32, 1'b0, 12, 32, -1);
        send_bits(1'b1, 64'h3C000000, 32, 1'b0, 0, 32, -1);
        repeat (2) send_frame(64'h66000000, 64'h22000000, 32, 1'b0, -1);
        drain("t6_ena");
        check("t6_ena_relocked", 64'(locked), 64'(m_locked));

        // randomized framing, lengths (including beyond W), channel and alignment
        for (int f = 0; f < 10; f++) begin
            int   len;
            logic lj;
            len = lens[$urandom_range(0, 5)];
            lj  = 1'($urandom_range(0, 1));
            audio_chan_sel = 1'($urandom_range(0, 1));
            i2s_ws_align   = ($urandom_range(0, 3) == 0) ? ~lj : lj;
            send_frame({32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)}, len, lj, -1);
        end
        drain("rand");
        check("rand_locked", 64'(locked), 64'(m_locked));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
